ace_wr_order_queue: RTL and testbench
=====================================

Name: ace_wr_order_queue

Overview:
- Sits directly downstream of the 8-to-1 ACE interconnect write path, between it and the NoC master port.
- Records each accepted AW (source core index, burst length) in an in-order queue.
- Forwards W beats only for the burst at the queue head. Regenerates WLAST from a beat counter and flags any core WLAST mismatch.
- Bounds outstanding writes so W data can never be steered to the wrong burst when the arbiter re-grants.

Parameters:
- DEPTH, 8, max outstanding AW bursts awaiting W data (power of 2, ≥2)
- ADDR_W, 48, address width
- DATA_W, 512, write data width
- SRC_W, 3, source core index width (8 cores)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_awaddr  in  ADDR_W  address from interconnect
- s_awlen  in  8  burst length minus 1
- s_awsrc  in  SRC_W  granted core index
- s_awvalid  in  1  AW valid
- s_awready  out  1  AW ready
- s_wdata  in  DATA_W  write data
- s_wstrb  in  DATA_W/8  byte strobes
- s_wlast  in  1  core-supplied last
- s_wvalid  in  1  W valid
- s_wready  out  1  W ready
- m_awaddr  out  ADDR_W  to NoC
- m_awlen  out  8  to NoC
- m_awsrc  out  SRC_W  to NoC (region/ID tag)
- m_awvalid  out  1  to NoC
- m_awready  in  1  from NoC
- m_wdata  out  DATA_W  to NoC
- m_wstrb  out  DATA_W/8  to NoC
- m_wlast  out  1  regenerated last
- m_wvalid  out  1  to NoC
- m_wready  in  1  from NoC
- wsrc  out  SRC_W  core index owning current W beat (drives interconnect W mux)
- outstanding  out  $clog2(DEPTH+1)  queue occupancy
- wlast_err  out  1  one-cycle error pulse
- wlast_err_src  out  SRC_W  source of last error, held until next error

Behaviour:
- AW path is combinational pass-through. m_aw* = s_aw*.
  - m_awvalid = s_awvalid & ~full & ~rst.
  - s_awready = m_awready & ~full & ~rst.
- Push {awlen, awsrc} on the m_aw handshake.
- full = (occupancy == DEPTH). There is no bypass: when full, a push is refused even if a pop happens in the same cycle.
- W path:
  - m_wvalid = s_wvalid & ~empty & ~rst.
  - s_wready = m_wready & ~empty & ~rst.
  - m_wdata/m_wstrb pass straight through.
  - wsrc = head.src.
- W beats arriving before their AW are held (ready low). Minimum latency is 1 cycle from the AW handshake to the first W handshake of that burst (no empty-queue bypass).
- Beat counter (8 bits) starts at 0 and increments on each W handshake.
  - m_wlast = (beat_cnt == head.len) & ~empty.
  - On the last-beat handshake: beat_cnt ← 0 and the head is popped.
- awlen = 0 means a single beat: m_wlast is high on the first beat.
- Simultaneous push and pop (not full): occupancy unchanged, pointers both advance, wrap modulo DEPTH.
- WLAST check on each W handshake:
  - If s_wlast ≠ m_wlast, wlast_err is 1 in the following cycle and wlast_err_src ← head.src.
  - The burst still completes per the counter. Beats from the core past the counted length stay with the next queue entry.
- outstanding = occupancy, registered.
- Reset (also mid-burst):
  - Pointers, occupancy and beat_cnt ← 0.
  - wlast_err ← 0; wlast_err_src ← 0.
  - m_awvalid, s_awready, m_wvalid and s_wready are 0 while rst is high.
  - In-flight bursts are discarded.
- No combinational path from m_wready to s_awready beyond the full flag.

Decomposition:
- Shared package cpu_cluster_pkg holds:
  - SRC_W, DEPTH default, LEN_W = 8
  - typedef wr_ord_entry_t {logic [7:0] len; logic [SRC_W-1:0] src;}
- Sub-module: sync_fifo_ctrl, a pointer/occupancy FIFO with flops storing wr_ord_entry_t. It exposes push, pop, full, empty, count and head.
- Beat counter, WLAST check and handshake gating stay in the top.

Test Plan:
- One AW (src=3, len=3), then 4 W beats with s_wlast on beat 4 → m_wlast only on beat 4, wsrc=3 throughout, outstanding goes 1→0, no wlast_err.
- W valid held high with no AW, then AW (len=0) at cycle 5 → s_wready=0 through cycle 5; single beat accepted at cycle 6 with m_wlast=1.
- 8 back-to-back AWs (len=1, src 0..7) with W stalled, then a 9th AW → outstanding=8 and s_awready=0 for the 9th. Drain W → 16 beats, wsrc sequence 0,0,1,1…7,7; 9th AW accepted only after the first pop.
- AW (src=5, len=2) with core asserting s_wlast on beat 2 → wlast_err pulse in the cycle after beat 2, wlast_err_src=5. m_wlast still asserted on beat 3.
- Full queue with AW and last-W handshake in the same cycle → the AW is refused that cycle and accepted the next cycle; occupancy goes 8→7→8.
- rst asserted for 1 cycle mid-burst (beat 2 of len=7) → all valids/readies 0 during rst, outstanding=0 after, and a new AW (len=0) completes normally.

Source files
------------

// File: rtl/cpu_cluster_pkg.sv
// Shared cluster types for the write-ordering path.
// Queue entry layout and default sizing constants.
package cpu_cluster_pkg;

    localparam int SRC_W        = 3;
    localparam int WR_ORD_DEPTH = 8;
    localparam int LEN_W        = 8;

    typedef struct packed {
        logic [LEN_W-1:0] len;
        logic [SRC_W-1:0] src;
    } wr_ord_entry_t;

endpackage

// File: rtl/sync_fifo_ctrl.sv
// Pointer/occupancy FIFO holding write-order entries.
// Caller guarantees no push when full and no pop when empty.
module sync_fifo_ctrl
    import cpu_cluster_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  wr_ord_entry_t din,
    output logic          full,
    output logic          empty,
    output logic [CNT_W-1:0] count,
    output wr_ord_entry_t head
);

    localparam int PTR_W = $clog2(DEPTH);

    wr_ord_entry_t    mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Entry storage, written at the tail on push.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/ace_wr_order_queue.sv
// Keeps W data in AW order behind the 8-to-1 write interconnect.
// Regenerates WLAST from a beat counter and flags core mismatches.
module ace_wr_order_queue #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 48,
    parameter int DATA_W = 512,
    parameter int SRC_W  = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W-1:0]          s_awaddr,
    input  logic [7:0]                 s_awlen,
    input  logic [SRC_W-1:0]           s_awsrc,
    input  logic                       s_awvalid,
    output logic                       s_awready,
    input  logic [DATA_W-1:0]          s_wdata,
    input  logic [DATA_W/8-1:0]        s_wstrb,
    input  logic                       s_wlast,
    input  logic                       s_wvalid,
    output logic                       s_wready,
    output logic [ADDR_W-1:0]          m_awaddr,
    output logic [7:0]                 m_awlen,
    output logic [SRC_W-1:0]           m_awsrc,
    output logic                       m_awvalid,
    input  logic                       m_awready,
    output logic [DATA_W-1:0]          m_wdata,
    output logic [DATA_W/8-1:0]        m_wstrb,
    output logic                       m_wlast,
    output logic                       m_wvalid,
    input  logic                       m_wready,
    output logic [SRC_W-1:0]           wsrc,
    output logic [$clog2(DEPTH+1)-1:0] outstanding,
    output logic                       wlast_err,
    output logic [SRC_W-1:0]           wlast_err_src
);

    import cpu_cluster_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic          full;
    logic          empty;
    logic          aw_hs;
    logic          w_hs;
    logic          pop;
    logic [7:0]    beat_cnt;
    wr_ord_entry_t head;
    wr_ord_entry_t din;

    assign din = '{len: s_awlen, src: s_awsrc};

    sync_fifo_ctrl #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (aw_hs),
        .pop   (pop),
        .din   (din),
        .full  (full),
        .empty (empty),
        .count (outstanding),
        .head  (head)
    );

    assign m_awaddr  = s_awaddr;
    assign m_awlen   = s_awlen;
    assign m_awsrc   = s_awsrc;
    assign m_awvalid = s_awvalid & ~full & ~rst;
    assign s_awready = m_awready & ~full & ~rst;
    assign aw_hs     = s_awvalid & m_awready & ~full & ~rst;

    assign m_wdata  = s_wdata;
    assign m_wstrb  = s_wstrb;
    assign m_wvalid = s_wvalid & ~empty & ~rst;
    assign s_wready = m_wready & ~empty & ~rst;
    assign w_hs     = s_wvalid & m_wready & ~empty & ~rst;
    assign wsrc     = head.src;
    assign m_wlast  = (beat_cnt == head.len) & ~empty;
    assign pop      = w_hs & m_wlast;

    // Beat position within the head burst; wraps to 0 on the last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (pop) begin
            beat_cnt <= '0;
        end else if (w_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
        end
    end

    // Compare core WLAST with the counted one on every accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            wlast_err     <= 1'b0;
            wlast_err_src <= '0;
        end else begin
            wlast_err <= w_hs & (s_wlast != m_wlast);
            if (w_hs & (s_wlast != m_wlast)) begin
                wlast_err_src <= head.src;
            end
        end
    end

endmodule

// File: tb/tb_ace_wr_order_queue.sv
// Randomized scoreboard bench for ace_wr_order_queue.
// Burst-level model predicts occupancy, W routing, WLAST and errors.
module tb_ace_wr_order_queue;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 48;
    localparam int DATA_W = 512;
    localparam int SRC_W  = 3;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [ADDR_W-1:0]   s_awaddr = '0;
    logic [7:0]          s_awlen = '0;
    logic [SRC_W-1:0]    s_awsrc = '0;
    logic                s_awvalid = 1'b0;
    logic                s_awready;
    logic [DATA_W-1:0]   s_wdata = '0;
    logic [DATA_W/8-1:0] s_wstrb = '0;
    logic                s_wlast = 1'b0;
    logic                s_wvalid = 1'b0;
    logic                s_wready;
    logic [ADDR_W-1:0]   m_awaddr;
    logic [7:0]          m_awlen;
    logic [SRC_W-1:0]    m_awsrc;
    logic                m_awvalid;
    logic                m_awready = 1'b0;
    logic [DATA_W-1:0]   m_wdata;
    logic [DATA_W/8-1:0] m_wstrb;
    logic                m_wlast;
    logic                m_wvalid;
    logic                m_wready = 1'b0;
    logic [SRC_W-1:0]    wsrc;
    logic [3:0]          outstanding;
    logic                wlast_err;
    logic [SRC_W-1:0]    wlast_err_src;

    ace_wr_order_queue #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRC_W(SRC_W)
    ) dut (
        .clk(clk), .rst(rst),
        .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsrc(s_awsrc),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_wvalid(s_wvalid), .s_wready(s_wready),
        .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsrc(m_awsrc),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_wvalid(m_wvalid), .m_wready(m_wready),
        .wsrc(wsrc), .outstanding(outstanding),
        .wlast_err(wlast_err), .wlast_err_src(wlast_err_src)
    );

    always #5 clk = ~clk;

    typedef struct {
        int src;
        int len;
    } burst_t;

    // Model state always reflects the DUT after the coming rising edge.
    burst_t mq[$];
    int     midx = 0;
    bit     err_exp = 1'b0;
    int     err_src_exp = 0;

    int total = 0;
    int bad = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s at %0t: got %0d expected %0d",
                         name, $time, act, exp);
        end
    endtask

    function automatic bit model_last();
        return (mq.size() > 0) && (midx == mq[0].len);
    endfunction

    // Monitor: compare outputs each falling edge, then advance the model.
    always @(negedge clk) begin
        bit full_m, emp_m, aw_hs, w_hs, last;
        if (rst) begin
            chk("rst_m_awvalid", 64'(m_awvalid), 0);
            chk("rst_s_awready", 64'(s_awready), 0);
            chk("rst_m_wvalid", 64'(m_wvalid), 0);
            chk("rst_s_wready", 64'(s_wready), 0);
            mq.delete();
            midx = 0;
            err_exp = 1'b0;
            err_src_exp = 0;
        end else begin
            full_m = (mq.size() >= DEPTH);
            emp_m  = (mq.size() == 0);
            last   = model_last();
            chk("outstanding", 64'(outstanding), 64'(mq.size()));
            chk("wlast_err", 64'(wlast_err), 64'(err_exp));
            chk("wlast_err_src", 64'(wlast_err_src), 64'(err_src_exp));
            chk("s_awready", 64'(s_awready), 64'(m_awready && !full_m));
            chk("m_awvalid", 64'(m_awvalid), 64'(s_awvalid && !full_m));
            chk("s_wready", 64'(s_wready), 64'(m_wready && !emp_m));
            chk("m_wvalid", 64'(m_wvalid), 64'(s_wvalid && !emp_m));
            chk("aw_pass", 64'(m_awaddr == s_awaddr && m_awlen == s_awlen
                               && m_awsrc == s_awsrc), 1);
            if (!emp_m && s_wvalid) begin
                chk("wsrc", 64'(wsrc), 64'(mq[0].src));
                chk("m_wlast", 64'(m_wlast), 64'(last));
                chk("w_pass", 64'(m_wdata == s_wdata
                                  && m_wstrb == s_wstrb), 1);
            end
            aw_hs = s_awvalid && m_awready && !full_m;
            w_hs  = s_wvalid && m_wready && !emp_m;
            err_exp = w_hs && (s_wlast != last);
            if (err_exp) err_src_exp = mq[0].src;
            if (w_hs) begin
                if (last) begin
                    void'(mq.pop_front());
                    midx = 0;
                end else begin
                    midx++;
                end
            end
            if (aw_hs) mq.push_back('{int'(s_awsrc), int'(s_awlen)});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_aw(int src, int len);
        s_awaddr  = {$urandom, $urandom} & 48'hFFFF_FFFF_FFC0;
        s_awsrc   = SRC_W'(src);
        s_awlen   = 8'(len);
        s_awvalid = 1'b1;
    endtask

    task automatic rand_w();
        s_wdata = {16{$urandom}};
        s_wstrb = {2{$urandom}};
    endtask

    // Drain all queued bursts with correct core WLAST; optional AW pending.
    task automatic drain(int budget);
        bit done = 1'b0;
        s_wvalid = 1'b1;
        m_wready = 1'b1;
        for (int c = 0; c < budget; c++) begin
            bit acc;
            rand_w();
            s_wlast = model_last();
            acc = s_awvalid && s_awready;
            step();
            if (acc) s_awvalid = 1'b0;
            if (!s_awvalid && mq.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        chk("drain_done", 64'(done), 1);
        s_wvalid = 1'b0;
        s_wlast  = 1'b0;
    endtask

    initial begin
        repeat (3) step();
        rst = 1'b0;
        step();

        // Single 4-beat burst from core 3.
        m_awready = 1'b1;
        send_aw(3, 3);
        step();
        s_awvalid = 1'b0;
        s_wvalid = 1'b1;
        m_wready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            rand_w();
            s_wlast = (b == 3);
            step();
        end
        s_wvalid = 1'b0;
        step();

        // W waits for its AW; first beat one cycle after AW.
        s_wvalid = 1'b1;
        s_wlast = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chk("w_held", 64'(s_wready), 0);
            step();
        end
        send_aw(6, 0);
        chk("w_held_aw", 64'(s_wready), 0);
        step();
        s_awvalid = 1'b0;
        chk("w_after_aw", 64'(s_wready && m_wlast), 1);
        step();
        s_wvalid = 1'b0;
        step();

        // Fill to DEPTH with W stalled, ninth AW refused until a pop.
        m_wready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send_aw(i, 1);
            step();
        end
        send_aw(0, 1);
        step();
        chk("full_out", 64'(outstanding), 8);
        chk("full_awready", 64'(s_awready), 0);
        drain(60);
        step();

        // Early core WLAST on beat 2 of a 3-beat burst from core 5.
        send_aw(5, 2);
        step();
        s_awvalid = 1'b0;
        s_wvalid = 1'b1;
        m_wready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            rand_w();
            s_wlast = (b == 1);
            if (b == 2) chk("late_mwlast", 64'(m_wlast), 1);
            step();
            if (b == 1) chk("err_src5", 64'(wlast_err && wlast_err_src == 5), 1);
        end
        s_wvalid = 1'b0;
        step();

        // Full queue, AW and final W beat in the same cycle.
        m_wready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send_aw(i, 0);
            step();
        end
        s_awvalid = 1'b0;
        step();
        send_aw(7, 0);
        s_wvalid = 1'b1;
        s_wlast = 1'b1;
        m_wready = 1'b1;
        chk("same_cyc_refuse", 64'(s_awready), 0);
        step();
        s_wvalid = 1'b0;
        chk("pop_to7", 64'(outstanding), 7);
        chk("next_accept", 64'(s_awready), 1);
        step();
        s_awvalid = 1'b0;
        chk("back_to8", 64'(outstanding), 8);
        drain(40);
        step();

        // Reset in the middle of an 8-beat burst.
        send_aw(2, 7);
        step();
        s_awvalid = 1'b0;
        s_wvalid = 1'b1;
        s_wlast = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_out", 64'(outstanding), 0);
        chk("rst_wready", 64'(s_wready), 0);
        s_wvalid = 1'b0;
        send_aw(4, 0);
        step();
        s_awvalid = 1'b0;
        drain(10);
        step();

        // Randomized traffic with occasional WLAST faults.
        for (int c = 0; c < 2000; c++) begin
            if (s_awvalid == 1'b0 || $urandom_range(0, 3) == 0)
                send_aw(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
            s_awvalid = ($urandom_range(0, 2) != 0);
            m_awready = ($urandom_range(0, 3) != 0);
            s_wvalid  = ($urandom_range(0, 3) != 0);
            m_wready  = ($urandom_range(0, 3) != 0);
            rand_w();
            s_wlast = model_last() ^ ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 499) == 0) rst = 1'b1;
            step();
            rst = 1'b0;
        end
        s_awvalid = 1'b0;
        m_awready = 1'b1;
        drain(200);
        repeat (2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
